mem_seq_ctrl: RTL
=================

Name: mem_seq_ctrl

Overview:
- Sequencer for the on-board 32-entry synchronous memory.
- Runs a full-array FILL pass, writing pattern data = seed + addr, or a VERIFY pass, reading every location back and checking it against the same pattern.
- Reports completion, the error count and the first failing address, so the 7-segment display logic can show pass/fail without manual switch stepping.
- Sits between the top-level control (button/switch decode) and the memory port; it is the memory's only requester while busy.

Parameters:
- ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W locations.
- DATA_W, 16, memory data width (one hex digit per FND, 4 digits).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request pulse; accepted only in IDLE.
- op  input  1  0 = FILL, 1 = VERIFY; sampled with an accepted start.
- seed  input  DATA_W  pattern base; sampled with an accepted start.
- abort  input  1  terminates the pass early.
- mem_addr  output  ADDR_W  memory address.
- mem_we  output  1  write strobe.
- mem_wdata  output  DATA_W  write data.
- mem_re  output  1  read strobe; memory returns mem_rdata one cycle later.
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_re.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a completed pass.
- err_cnt  output  ADDR_W+1  mismatch count for the last VERIFY pass, 0..DEPTH.
- fail_valid  output  1  at least one mismatch seen since the last accepted start.
- fail_addr  output  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset (async, n_rst=0): state IDLE. All of the following are 0: mem_addr, mem_we, mem_wdata, mem_re, busy, done, err_cnt, fail_valid, fail_addr. Internal op/seed registers are cleared.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE, on start=1 and abort=0:
  - latch op and seed;
  - clear err_cnt, fail_valid and fail_addr;
  - address counter = 0;
  - go to WRITE (op=0) or READ (op=1).
- start outside IDLE is ignored. start and abort together in IDLE: abort wins, no pass starts.
- WRITE:
  - each cycle: mem_we=1, mem_addr=cnt, mem_wdata = seed + cnt, zero-extended, modulo 2**DATA_W (wraps, no carry out);
  - cnt increments; after cnt = DEPTH-1 go to DONE;
  - exactly DEPTH write cycles.
- READ:
  - each cycle: mem_re=1, mem_addr=cnt, cnt increments;
  - after cnt = DEPTH-1 go to DRAIN;
  - exactly DEPTH read cycles.
- Compare, one cycle after each mem_re (in READ and in DRAIN):
  - mismatch when mem_rdata != seed + prev_addr;
  - on a mismatch, err_cnt increments;
  - on the first mismatch of a pass, fail_valid=1 and fail_addr=prev_addr; later mismatches leave fail_addr unchanged.
- DRAIN: one cycle; mem_re=0; the last address is compared; then go to DONE.
- DONE: one cycle; done=1, busy=1; then go to IDLE.
- Strobes: mem_we and mem_re are never both 1. Both are 0 in IDLE, DRAIN and DONE. mem_addr holds its last value when not strobing.
- Latency, from the start-sampling edge E0:
  - FILL: writes occupy cycles 1..DEPTH; done is high in cycle DEPTH+1 (33).
  - VERIFY: reads occupy cycles 1..DEPTH; DRAIN is cycle DEPTH+1; done is high in cycle DEPTH+2 (34).
  - busy deasserts the cycle after done.
- abort=1 in any non-IDLE state:
  - next state IDLE; mem_we/mem_re are 0 from the next cycle; no done pulse;
  - err_cnt, fail_valid and fail_addr hold their partial values;
  - a compare pending for a read already issued is discarded.
- Reset mid-pass: immediate asynchronous return to the reset values; no done pulse.
- FILL passes leave err_cnt/fail_* at 0 (cleared at start).
- Back-to-back operation: start in the cycle after done (state IDLE) is accepted.

Test Plan:
- FILL, seed=0x1200: start pulse → mem_we high for exactly 32 consecutive cycles, addr 0..31, wdata 0x1200..0x121F; done pulse 33 cycles after the start edge; busy low afterwards.
- VERIFY after that FILL (bench memory model, 1-cycle read latency): start, op=1, seed=0x1200 → 32 reads, done at cycle 34, err_cnt=0, fail_valid=0, fail_addr=0.
- Wrap-around: FILL then VERIFY with seed=0xFFF0 → addr 15 holds 0xFFFF, addr 16 holds 0x0000, addr 31 holds 0x000F; VERIFY err_cnt=0.
- Error injection: bench corrupts addr 7 and addr 20 after FILL → VERIFY gives err_cnt=2, fail_valid=1, fail_addr=7; VERIFY with seed=0x0000 against 0x1200 data gives err_cnt=32, fail_addr=0.
- Abort: abort asserted at read cycle 10 → busy low next cycle, no done pulse, mem_re low; a new start is then accepted and runs a full pass with err_cnt re-cleared.
- Ignored and conflicting requests: start during WRITE does not restart the pass (addresses continue in sequence); start+abort in IDLE → busy stays 0; n_rst pulsed low mid-WRITE → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_seq_ctrl.sv
// Fill/verify sequencer for the on-board synchronous memory: writes seed+addr
// to every location, or reads every location back and checks it.
module mem_seq_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] seed,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, prev_addr;
  logic              op_q;
  logic [DATA_W-1:0] seed_q;
  logic              rd_pend;
  logic              accept, cmp_en, mismatch;

  assign accept   = (state == S_IDLE) && start && !abort;
  // A compare landing in the abort cycle belongs to a cancelled pass.
  assign cmp_en   = rd_pend && op_q && !abort;
  assign mismatch = mem_rdata != (seed_q + DATA_W'(prev_addr));

  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) state_nx = op ? S_READ : S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (abort)             state_nx = S_IDLE;
        else if (cnt == LAST)  state_nx = S_DONE;
      end
      S_READ: begin
        mem_re = 1'b1;
        if (abort)             state_nx = S_IDLE;
        else if (cnt == LAST)  state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        state_nx = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Counter saturates at LAST, so the address holds once strobing stops.
    mem_addr  = cnt;
    mem_wdata = mem_we ? (seed_q + DATA_W'(cnt)) : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt        <= '0;
      prev_addr  <= '0;
      op_q       <= 1'b0;
      seed_q     <= '0;
      rd_pend    <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
    end else begin
      rd_pend <= (state == S_READ) && !abort;
      if (state == S_READ) prev_addr <= cnt;
      if (accept) begin
        op_q       <= op;
        seed_q     <= seed;
        cnt        <= '0;
        err_cnt    <= '0;
        fail_valid <= 1'b0;
        fail_addr  <= '0;
      end else begin
        if ((mem_we || mem_re) && !abort && cnt != LAST) cnt <= cnt + 1'b1;
        if (cmp_en && mismatch) begin
          err_cnt <= err_cnt + 1'b1;
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_addr  <= prev_addr;
          end
        end
      end
    end
  end

endmodule
